ks_pluck_voice: RTL and testbench

Parametrised single-voice Karplus-Strong plucked-string generator, the successor of the fixed-length `music_synthesizer`. It fills a circular delay line of run-time-selectable length from an internal LFSR noise burst, then streams averaged feedback samples over a valid/ready handshake. Notes are re-triggerable and can be stopped explicitly or after a sample budget. Several instances sit behind a future voice mixer.

---
 rtl/ks_pkg.sv | 19 +
 rtl/ks_lfsr.sv | 31 +++
 rtl/ks_pluck_voice.sv | 133 +++++++++++++
 tb/tb_ks_pluck_voice.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared types and constants for the Karplus-Strong plucked-string voice.
package ks_pkg;

  typedef enum logic [1:0] {
    KS_IDLE = 2'd0,
    KS_FILL = 2'd1,
    KS_RUN  = 2'd2
  } ks_state_t;

  localparam int                    KS_LFSR_W    = 16;
  localparam logic [KS_LFSR_W-1:0] KS_LFSR_MASK = 16'hB400;
  localparam logic [KS_LFSR_W-1:0] KS_SEED_DEF  = 16'hACE1;

  // Galois right-shift step: the mask is applied when the shifted-out bit is 1.
  function automatic logic [KS_LFSR_W-1:0] ks_lfsr_next(input logic [KS_LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? KS_LFSR_MASK : '0);
  endfunction

endpackage

// File: rtl/ks_lfsr.sv
// 16-bit Galois noise source for the string fill; a zero seed selects the default seed.
module ks_lfsr
  import ks_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [KS_LFSR_W-1:0] seed_i,
  input  logic                 step_i,
  output logic [KS_LFSR_W-1:0] state_o
);

  logic [KS_LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? KS_SEED_DEF : seed_i;
    end else if (step_i) begin
      state_d = ks_lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= KS_SEED_DEF;
    else         state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/ks_pluck_voice.sv
// Single-voice Karplus-Strong generator: LFSR-filled ring, averaged feedback, valid/ready out.
// Optional per-pass energy loss is enabled by defining KS_DECAY_EN.
module ks_pluck_voice
  import ks_pkg::*;
#(
  parameter int W           = 8,
  parameter int MAX_L       = 256,
  parameter int NOTE_LEN    = 0,
  parameter int DECAY_SHIFT = 6,
  parameter int LW          = $clog2(MAX_L) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          PLUCK,
  input  logic [LW-1:0] LEN,
  input  logic [15:0]   SEED,
  input  logic          STOP,
  output logic [W-1:0]  O,
  output logic          O_VALID,
  input  logic          O_READY,
  output logic          BUSY
);

  localparam int AW = LW - 1;
`ifdef KS_DECAY_EN
  localparam bit DecayEn = 1'b1;
`else
  localparam bit DecayEn = 1'b0;
`endif

  ks_state_t             state_q, state_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [LW-1:0]         len_q, len_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [W-1:0]          ring_q [MAX_L];

  logic [KS_LFSR_W-1:0]  lfsr_q;
  logic                  lfsr_load, lfsr_step;
  logic                  unused_lfsr;
  logic                  ring_we, hs;
  logic [W-1:0]          ring_wdata;
  logic [LW-1:0]         len_clamped, ptr_inc;
  logic [AW-1:0]         ptr_wrap;
  logic signed [W-1:0]   cur, nxt, avg, wval;
  logic signed [W:0]     sum, sum_sh;

  ks_lfsr u_lfsr (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .load_i  (lfsr_load),
    .seed_i  (SEED),
    .step_i  (lfsr_step),
    .state_o (lfsr_q)
  );
  assign unused_lfsr = ^lfsr_q;

  assign len_clamped = (LEN < LW'(2))     ? LW'(2)     :
                       (LEN > LW'(MAX_L)) ? LW'(MAX_L) : LEN;

  // Same wrap serves the fill index (end of fill) and the run pointer (mod L).
  assign ptr_inc  = {1'b0, ptr_q} + LW'(1);
  assign ptr_wrap = (ptr_inc == len_q) ? '0 : ptr_inc[AW-1:0];

  assign cur    = ring_q[ptr_q];
  assign nxt    = ring_q[ptr_wrap];
  assign sum    = {cur[W-1], cur} + {nxt[W-1], nxt};
  assign sum_sh = sum >>> 1;
  assign avg    = sum_sh[W-1:0];
  assign wval   = DecayEn ? (avg - (avg >>> DECAY_SHIFT)) : avg;

  assign hs      = (state_q == KS_RUN) && O_READY;
  assign O_VALID = (state_q == KS_RUN);
  assign BUSY    = (state_q != KS_IDLE);
  assign O       = O_VALID ? cur : '0;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    ring_we    = 1'b0;
    ring_wdata = '0;
    if (PLUCK) begin
      len_d     = len_clamped;
      lfsr_load = 1'b1;
      ptr_d     = '0;
      cnt_d     = '0;
      state_d   = KS_FILL;
    end else begin
      case (state_q)
        KS_FILL: begin
          ring_we    = 1'b1;
          ring_wdata = lfsr_q[KS_LFSR_W-1 -: W];
          lfsr_step  = 1'b1;
          ptr_d      = ptr_wrap;
          if (ptr_inc == len_q) state_d = KS_RUN;
        end
        KS_RUN: begin
          if (hs) begin
            ring_we    = 1'b1;
            ring_wdata = wval;
            ptr_d      = ptr_wrap;
            cnt_d      = cnt_q + 32'd1;
            if (NOTE_LEN != 0 && cnt_d == 32'(NOTE_LEN)) state_d = KS_IDLE;
          end
          if (STOP) state_d = KS_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= KS_IDLE;
      ptr_q   <= '0;
      len_q   <= LW'(2);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (ring_we) ring_q[ptr_q] <= ring_wdata;
  end

endmodule

// File: tb/tb_ks_pluck_voice.sv
// Scoreboard bench for ks_pluck_voice (W=8, MAX_L=256); honours KS_DECAY_EN in its model.
module tb_ks_pluck_voice;

  localparam int DSH = 6;
`ifdef KS_DECAY_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pluck = 1'b0, pluck2 = 1'b0, stop = 1'b0, o_ready = 1'b1;
  logic [8:0]  len = '0;
  logic [15:0] seed = '0;
  logic [7:0]  o, o2;
  logic        o_valid, o_valid2, busy, busy2;

  int          n_checks = 0;
  int          n_err = 0;
  int          hs1 = 0;
  int          hs2 = 0;
  logic [7:0]  q1[$];

  always #5 clk = ~clk;

  ks_pluck_voice #(.W(8), .MAX_L(256), .NOTE_LEN(0), .DECAY_SHIFT(DSH)) u_dut (
    .CLK(clk), .RST_N(rst_n), .PLUCK(pluck), .LEN(len), .SEED(seed), .STOP(stop),
    .O(o), .O_VALID(o_valid), .O_READY(o_ready), .BUSY(busy)
  );

  ks_pluck_voice #(.W(8), .MAX_L(256), .NOTE_LEN(10), .DECAY_SHIFT(DSH)) u_dut_as (
    .CLK(clk), .RST_N(rst_n), .PLUCK(pluck2), .LEN(len), .SEED(seed), .STOP(stop),
    .O(o2), .O_VALID(o_valid2), .O_READY(o_ready), .BUSY(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Golden note: fill from the noise source, then n averaged feedback samples.
  task automatic gen(input int len_in, input logic [15:0] sd, input int n);
    int         L, p, a, b, avg;
    logic [15:0] s;
    logic [7:0]  r[256];
    L = (len_in < 2) ? 2 : ((len_in > 256) ? 256 : len_in);
    s = (sd == 16'h0) ? 16'hACE1 : sd;
    for (int i = 0; i < L; i++) begin
      r[i] = s[15:8];
      s = m_step(s);
    end
    q1.delete();
    p = 0;
    for (int k = 0; k < n; k++) begin
      q1.push_back(r[p]);
      a = int'($signed(r[p]));
      b = int'($signed(r[(p + 1) % L]));
      avg = (a + b) >>> 1;
      if (DEC) avg = avg - (avg >>> DSH);
      r[p] = 8'(avg);
      p = (p + 1) % L;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_pluck(input int l, input logic [15:0] sd, input int n);
    len  = 9'(l);
    seed = sd;
    gen(l, sd, n);
    pluck = 1'b1;
    tick();
    pluck = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid && n < 400) begin
      n++;
      tick();
    end
  endtask

  task automatic stop_note();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && !pluck && o_valid && o_ready) begin
      if (q1.size() == 0) chk("extra_sample", 32'(o_valid), 32'd0);
      else begin
        chk("sample", 32'(o), 32'(q1.pop_front()));
        hs1++;
      end
    end
    if (rst_n && !pluck2 && o_valid2 && o_ready) hs2++;
  end

  initial begin
    int n, h;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Fill pattern and first averaged samples
    do_pluck(4, 16'hACE1, 64);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_fill", 32'(o_valid), 32'd0);
    wait_valid(n);
    chk("t1_fill_cycles", 32'(n), 32'd4);
    chk("t1_first", 32'(o), 32'hAC);
    h = hs1;
    repeat (5) tick();
    chk("t1_hs_count", 32'(hs1 - h), 32'd5);

    // Backpressure holds the sample
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", 32'(o), 32'(q1[0]));
      chk("bp_valid", 32'(o_valid), 32'd1);
      tick();
    end
    o_ready = 1'b1;
    h = hs1;
    repeat (4) tick();
    chk("bp_resume_count", 32'(hs1 - h), 32'd4);

    stop_note();
    chk("stop_valid", 32'(o_valid), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    h = hs1;
    tick();
    chk("stop_no_hs", 32'(hs1 - h), 32'd0);

    // Lower clamp: period-2 string
    do_pluck(1, 16'h1234, 40);
    wait_valid(n);
    chk("clamp_lo_fill", 32'(n), 32'd2);
    h = hs1;
    repeat (8) tick();
    chk("clamp_lo_count", 32'(hs1 - h), 32'd8);

    // PLUCK and STOP together in RUN: retrigger wins
    stop = 1'b1;
    do_pluck(6, 16'h0F0F, 40);
    stop = 1'b0;
    chk("retrig_valid", 32'(o_valid), 32'd0);
    chk("retrig_busy", 32'(busy), 32'd1);
    wait_valid(n);
    chk("retrig_fill", 32'(n), 32'd6);
    repeat (6) tick();
    stop_note();

    // Upper clamp, zero seed, STOP ignored during FILL
    do_pluck(300, 16'h0000, 20);
    stop_note();
    chk("fill_stop_busy", 32'(busy), 32'd1);
    wait_valid(n);
    chk("clamp_hi_fill", 32'(n + 1), 32'd256);
    chk("seed0_first", 32'(o), 32'hAC);
    repeat (5) tick();
    stop_note();

    // Auto-stop after NOTE_LEN handshakes
    len = 9'd4;
    seed = 16'h5A5A;
    pluck2 = 1'b1;
    tick();
    pluck2 = 1'b0;
    h = hs2;
    n = 0;
    while (busy2 && n < 200) begin
      n++;
      tick();
    end
    chk("autostop_count", 32'(hs2 - h), 32'd10);
    chk("autostop_valid", 32'(o_valid2), 32'd0);
    chk("autostop_busy", 32'(busy2), 32'd0);

    // Asynchronous reset mid-RUN, then a clean restart
    do_pluck(5, 16'hC0DE, 40);
    wait_valid(n);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_o", 32'(o), 32'd0);
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_pluck(3, 16'hBEEF, 40);
    wait_valid(n);
    chk("post_rst_fill", 32'(n), 32'd3);
    h = hs1;
    repeat (8) tick();
    chk("post_rst_count", 32'(hs1 - h), 32'd8);
    stop_note();
    chk("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
